// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle collision checker.
// Optional feature macro used by the checker top: COLLISION_STATS_EN.
package obstacle_pkg;

    typedef enum logic [2:0] {
        OBS_NONE  = 3'd0,
        OBS_LOW   = 3'd1,
        OBS_HIGH  = 3'd2,
        OBS_MID   = 3'd3,
        OBS_TRAIN = 3'd4,
        OBS_RAMP  = 3'd5,
        OBS_CAR   = 3'd6
    } obs_type_e;

    localparam int HALF_BLOCK = 64;

    localparam int OBS_TYPE_MSB  = 15;
    localparam int OBS_TYPE_LSB  = 13;
    localparam int OBS_LANE_MSB  = 12;
    localparam int OBS_LANE_LSB  = 11;
    localparam int OBS_DEPTH_MSB = 10;
    localparam int OBS_DEPTH_LSB = 0;

    typedef enum logic [1:0] {
        CHK_IDLE,
        CHK_RECV,
        CHK_DRAIN,
        CHK_REPORT
    } chk_state_e;

    // Beat as held between the S1 and S2 stages.
    typedef struct packed {
        logic [2:0]  typ;
        logic [1:0]  lane;
        logic [11:0] depth;
        logic [11:0] start;
    } s1_beat_t;

    // Depth length of an obstacle: one half block for barriers,
    // two for trains, ramps and cars, nothing for unused codes.
    function automatic logic [11:0] obs_len(input logic [2:0] typ);
        logic [11:0] len;
        len = 12'd0;
        if (typ == OBS_LOW || typ == OBS_HIGH || typ == OBS_MID) begin
            len = 12'(HALF_BLOCK);
        end else if (typ == OBS_TRAIN || typ == OBS_RAMP || typ == OBS_CAR) begin
            len = 12'(2 * HALF_BLOCK);
        end
        return len;
    endfunction

endpackage

// File: rtl/obstacle_hit_eval.sv
// Combinational rule evaluation of one registered obstacle beat
// against the latched player state: hit flag and support height.
module obstacle_hit_eval
    import obstacle_pkg::*;
#(
    parameter int PLAYER_NEAR  = 16,
    parameter int PLAYER_FAR   = 48,
    parameter int JUMP_CLEAR   = 32,
    parameter int TRAIN_HEIGHT = 64
) (
    input  s1_beat_t    beat_i,
    input  logic [1:0]  lane_i,
    input  logic [7:0]  height_i,
    input  logic        duck_i,
    output logic        hit_o,
    output logic [7:0]  support_o
);

    localparam logic [11:0] NEAR12  = 12'(PLAYER_NEAR);
    localparam logic [11:0] FAR12   = 12'(PLAYER_FAR);
    localparam logic [11:0] TRAIN12 = 12'(TRAIN_HEIGHT);
    localparam logic [7:0]  JUMP8   = 8'(JUMP_CLEAR);
    localparam logic [7:0]  TRAIN8  = 8'(TRAIN_HEIGHT);

    logic        overlap;
    logic [11:0] ramp_gap;
    logic [11:0] ramp_half;

    // Overlap window test followed by the per-type hit/support rules.
    always_comb begin
        overlap   = (beat_i.lane == lane_i)
                 && (beat_i.start < FAR12)
                 && (beat_i.depth > NEAR12);
        ramp_gap  = NEAR12 - beat_i.start;
        ramp_half = ramp_gap >> 1;
        hit_o     = 1'b0;
        support_o = 8'd0;
        if (overlap) begin
            case (beat_i.typ)
                OBS_LOW: begin
                    hit_o = (height_i < JUMP8);
                end
                OBS_HIGH: begin
                    hit_o = !duck_i;
                end
                OBS_MID: begin
                    hit_o = !duck_i && (height_i < JUMP8);
                end
                OBS_TRAIN, OBS_CAR: begin
                    if (height_i >= TRAIN8) begin
                        support_o = TRAIN8;
                    end else begin
                        hit_o = 1'b1;
                    end
                end
                OBS_RAMP: begin
                    if (beat_i.start > NEAR12) begin
                        support_o = 8'd0;
                    end else if (ramp_half > TRAIN12) begin
                        support_o = TRAIN8;
                    end else begin
                        support_o = ramp_half[7:0];
                    end
                end
                default: begin
                    hit_o     = 1'b0;
                    support_o = 8'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/obstacle_collision_checker.sv
// Per-frame collision checker fed by the obstacle generator stream.
// Define COLLISION_STATS_EN to add the saturating hit_count output.
module obstacle_collision_checker
    import obstacle_pkg::*;
#(
    parameter int PLAYER_NEAR  = 16,
    parameter int PLAYER_FAR   = 48,
    parameter int JUMP_CLEAR   = 32,
    parameter int TRAIN_HEIGHT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        activate,
    input  logic [1:0]  player_lane,
    input  logic [7:0]  player_height,
    input  logic        player_duck,
    input  logic        obs_valid,
    input  logic        obs_first_row,
    input  logic [15:0] obs_data,
    input  logic        obs_done,
    output logic        busy,
    output logic        result_valid,
    output logic        collision,
    output logic [2:0]  collision_type,
    output logic [7:0]  ground_height
`ifdef COLLISION_STATS_EN
    ,
    output logic [7:0]  hit_count
`endif
);

    chk_state_e  state_q, state_d;
    logic        drain_q, drain_d;

    logic [1:0]  lane_q;
    logic [7:0]  height_q;
    logic        duck_q;

    s1_beat_t    s1_q, s1_d;
    logic        s1_vld_q, s1_vld_d;
    logic [11:0] s1_len;

    logic        eval_hit;
    logic [7:0]  eval_sup;

    logic        acc_hit_q, acc_hit_d;
    logic [2:0]  acc_type_q, acc_type_d;
    logic [7:0]  acc_gnd_q, acc_gnd_d;

    logic        coll_q;
    logic [2:0]  ctype_q;
    logic [7:0]  gnd_q;
    logic        load_result;

    logic        unused_first_row;
    assign unused_first_row = obs_first_row;

    // Next-state logic; activate restarts the frame from any state.
    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        if (activate) begin
            state_d = CHK_RECV;
        end else begin
            unique case (state_q)
                CHK_IDLE: begin
                    state_d = CHK_IDLE;
                end
                CHK_RECV: begin
                    if (obs_done) begin
                        state_d = CHK_DRAIN;
                    end
                end
                CHK_DRAIN: begin
                    drain_d = ~drain_q;
                    if (drain_q) begin
                        state_d = CHK_REPORT;
                    end
                end
                CHK_REPORT: begin
                    state_d = CHK_IDLE;
                end
                default: begin
                    state_d = CHK_IDLE;
                end
            endcase
        end
    end

    // State register and drain cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CHK_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Player state is captured once per frame on activate.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q   <= 2'd0;
            height_q <= 8'd0;
            duck_q   <= 1'b0;
        end else if (activate) begin
            lane_q   <= player_lane;
            height_q <= player_height;
            duck_q   <= player_duck;
        end
    end

    // S1: split the beat and derive its near-end depth, clamped at 0.
    always_comb begin
        s1_d.typ   = obs_data[OBS_TYPE_MSB:OBS_TYPE_LSB];
        s1_d.lane  = obs_data[OBS_LANE_MSB:OBS_LANE_LSB];
        s1_d.depth = {1'b0, obs_data[OBS_DEPTH_MSB:OBS_DEPTH_LSB]};
        s1_len     = obs_len(s1_d.typ);
        if (s1_d.depth < s1_len) begin
            s1_d.start = 12'd0;
        end else begin
            s1_d.start = s1_d.depth - s1_len;
        end
        s1_vld_d = obs_valid && (state_q == CHK_RECV) && !activate;
    end

    // S1 pipeline register; a restart drops any beat in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s1_vld_q <= s1_vld_d;
        end
    end

    obstacle_hit_eval #(
        .PLAYER_NEAR  (PLAYER_NEAR),
        .PLAYER_FAR   (PLAYER_FAR),
        .JUMP_CLEAR   (JUMP_CLEAR),
        .TRAIN_HEIGHT (TRAIN_HEIGHT)
    ) u_hit_eval (
        .beat_i    (s1_q),
        .lane_i    (lane_q),
        .height_i  (height_q),
        .duck_i    (duck_q),
        .hit_o     (eval_hit),
        .support_o (eval_sup)
    );

    // S2: accumulate first hit type and the highest support seen.
    always_comb begin
        acc_hit_d  = acc_hit_q;
        acc_type_d = acc_type_q;
        acc_gnd_d  = acc_gnd_q;
        if (activate) begin
            acc_hit_d  = 1'b0;
            acc_type_d = 3'd0;
            acc_gnd_d  = 8'd0;
        end else if (s1_vld_q) begin
            if (eval_hit && !acc_hit_q) begin
                acc_hit_d  = 1'b1;
                acc_type_d = s1_q.typ;
            end
            if (eval_sup > acc_gnd_q) begin
                acc_gnd_d = eval_sup;
            end
        end
    end

    // Frame accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hit_q  <= 1'b0;
            acc_type_q <= 3'd0;
            acc_gnd_q  <= 8'd0;
        end else begin
            acc_hit_q  <= acc_hit_d;
            acc_type_q <= acc_type_d;
            acc_gnd_q  <= acc_gnd_d;
        end
    end

    assign load_result = (state_d == CHK_REPORT);

    // Result registers, loaded on entry to REPORT and held until the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q  <= 1'b0;
            ctype_q <= 3'd0;
            gnd_q   <= 8'd0;
        end else if (load_result) begin
            coll_q  <= acc_hit_q;
            ctype_q <= acc_type_q;
            gnd_q   <= acc_gnd_q;
        end
    end

`ifdef COLLISION_STATS_EN
    logic [7:0] hit_count_q;

    // Saturating count of reported frames that collided.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q <= 8'd0;
        end else if (load_result && acc_hit_q && hit_count_q != 8'hFF) begin
            hit_count_q <= hit_count_q + 8'd1;
        end
    end

    assign hit_count = hit_count_q;
`endif

    assign busy           = (state_q == CHK_RECV) || (state_q == CHK_DRAIN);
    assign result_valid   = (state_q == CHK_REPORT);
    assign collision      = coll_q;
    assign collision_type = ctype_q;
    assign ground_height  = gnd_q;

endmodule

// File: tb/tb_obstacle_collision_checker.sv
// Randomized and directed bench for obstacle_collision_checker,
// checked against a frame-level behavioural model.
module tb_obstacle_collision_checker;

    localparam int NEAR  = 16;
    localparam int FAR   = 48;
    localparam int JUMP  = 32;
    localparam int TRAIN = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        activate;
    logic [1:0]  player_lane;
    logic [7:0]  player_height;
    logic        player_duck;
    logic        obs_valid;
    logic        obs_first_row;
    logic [15:0] obs_data;
    logic        obs_done;
    logic        busy;
    logic        result_valid;
    logic        collision;
    logic [2:0]  collision_type;
    logic [7:0]  ground_height;
`ifdef COLLISION_STATS_EN
    logic [7:0]  hit_count;
`endif

    always #5 clk = ~clk;

    obstacle_collision_checker dut (
        .clk            (clk),
        .rst            (rst),
        .activate       (activate),
        .player_lane    (player_lane),
        .player_height  (player_height),
        .player_duck    (player_duck),
        .obs_valid      (obs_valid),
        .obs_first_row  (obs_first_row),
        .obs_data       (obs_data),
        .obs_done       (obs_done),
        .busy           (busy),
        .result_valid   (result_valid),
        .collision      (collision),
        .collision_type (collision_type),
        .ground_height  (ground_height)
`ifdef COLLISION_STATS_EN
        ,
        .hit_count      (hit_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int rv_cnt = 0;
    int exp_hits = 0;

    int bt[8];
    int bl[8];
    int bd[8];
    int nb;

    int m_coll;
    int m_type;
    int m_gnd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (result_valid === 1'b1) rv_cnt++;
    end

    // Frame-level reference: plain arithmetic over the list of beats.
    task automatic model(input int lane, input int h, input int duck);
        m_coll = 0;
        m_type = 0;
        m_gnd  = 0;
        for (int i = 0; i < nb; i++) begin
            int len;
            int start;
            int hit;
            int sup;
            if (bt[i] >= 1 && bt[i] <= 3) len = 64;
            else if (bt[i] >= 4 && bt[i] <= 6) len = 128;
            else len = 0;
            start = bd[i] - len;
            if (start < 0) start = 0;
            hit = 0;
            sup = 0;
            if (bl[i] == lane && start < FAR && bd[i] > NEAR) begin
                case (bt[i])
                    1: hit = (h < JUMP) ? 1 : 0;
                    2: hit = duck ? 0 : 1;
                    3: hit = (!duck && h < JUMP) ? 1 : 0;
                    4, 6: begin
                        if (h >= TRAIN) sup = TRAIN;
                        else hit = 1;
                    end
                    5: begin
                        if (start <= NEAR) begin
                            sup = (NEAR - start) / 2;
                            if (sup > TRAIN) sup = TRAIN;
                        end
                    end
                    default: ;
                endcase
            end
            if (hit != 0 && m_coll == 0) begin
                m_coll = 1;
                m_type = bt[i];
            end
            if (sup > m_gnd) m_gnd = sup;
        end
    endtask

    task automatic put_beat(input int i);
        logic [2:0]  t;
        logic [1:0]  l;
        logic [10:0] d;
        t = 3'(bt[i]);
        l = 2'(bl[i]);
        d = 11'(bd[i]);
        obs_valid     = 1'b1;
        obs_first_row = (i == 0);
        obs_data      = {t, l, d};
    endtask

    task automatic run_frame(input int lane, input int h, input int duck,
                             input bit done_last, input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        activate      = 1'b1;
        player_lane   = 2'(lane);
        player_height = 8'(h);
        player_duck   = duck[0];
        @(negedge clk);
        activate = 1'b0;
        check({tag, "/busy"}, busy, 1);
        for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                obs_valid = 1'b0;
                @(negedge clk);
            end
            put_beat(i);
            if (done_last && i == nb - 1) begin
                obs_done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!(done_last && nb > 0)) begin
            obs_valid = 1'b0;
            obs_done  = 1'b1;
        end
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            @(negedge clk);
            obs_valid = 1'b0;
            obs_done  = 1'b0;
            lat++;
            if (result_valid === 1'b1) seen = 1'b1;
        end
        model(lane, h, duck);
        if (m_coll != 0 && exp_hits < 255) exp_hits++;
        check({tag, "/latency"}, lat, 3);
        check({tag, "/collision"}, collision, m_coll);
        check({tag, "/type"}, collision_type, m_type);
        check({tag, "/ground"}, ground_height, m_gnd);
`ifdef COLLISION_STATS_EN
        check({tag, "/hit_count"}, hit_count, exp_hits);
`endif
        @(negedge clk);
        check({tag, "/pulse"}, result_valid, 0);
        check({tag, "/held"}, collision, m_coll);
    endtask

    task automatic set1(input int t, input int l, input int d);
        nb    = 1;
        bt[0] = t;
        bl[0] = l;
        bd[0] = d;
    endtask

    initial begin
        int c0;
        rst           = 1'b1;
        activate      = 1'b0;
        player_lane   = 2'd0;
        player_height = 8'd0;
        player_duck   = 1'b0;
        obs_valid     = 1'b0;
        obs_first_row = 1'b0;
        obs_data      = 16'd0;
        obs_done      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/busy", busy, 0);
        check("reset/rv", result_valid, 0);
        check("reset/collision", collision, 0);
        check("reset/type", collision_type, 0);
        check("reset/ground", ground_height, 0);
        rst = 1'b0;

        set1(1, 1, 40);
        run_frame(1, 0, 0, 1, "low_hit");
        run_frame(1, 40, 0, 0, "low_jump");
        set1(4, 0, 100);
        run_frame(0, 64, 0, 1, "train_top");
        run_frame(0, 10, 0, 0, "train_hit");
        set1(5, 2, 128);
        run_frame(2, 0, 0, 1, "ramp");

        c0 = rv_cnt;
        @(negedge clk);
        activate      = 1'b1;
        player_lane   = 2'd1;
        player_height = 8'd0;
        player_duck   = 1'b0;
        @(negedge clk);
        activate = 1'b0;
        set1(1, 1, 40);
        put_beat(0);
        @(negedge clk);
        obs_valid = 1'b0;
        repeat (3) @(negedge clk);
        run_frame(1, 40, 0, 1, "abort");
        check("abort/rv_count", rv_cnt - c0, 1);

        nb    = 2;
        bt[0] = 1; bl[0] = 2; bd[0] = 40;
        bt[1] = 5; bl[1] = 2; bd[1] = 128;
        run_frame(2, 0, 0, 0, "pre_rst");

        @(negedge clk);
        activate    = 1'b1;
        player_lane = 2'd2;
        @(negedge clk);
        activate = 1'b0;
        put_beat(0);
        @(negedge clk);
        obs_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        exp_hits = 0;
        check("rst/busy", busy, 0);
        check("rst/rv", result_valid, 0);
        check("rst/collision", collision, 0);
        check("rst/type", collision_type, 0);
        check("rst/ground", ground_height, 0);
        c0 = rv_cnt;
        for (int i = 0; i < 3; i++) begin
            put_beat(i % 2);
            obs_done = 1'b1;
            @(negedge clk);
        end
        obs_valid = 1'b0;
        obs_done  = 1'b0;
        repeat (6) @(negedge clk);
        check("rst/ignored_rv", rv_cnt - c0, 0);
        check("rst/ignored_busy", busy, 0);
        check("rst/ignored_coll", collision, 0);

        for (int f = 0; f < 40; f++) begin
            int hs[8];
            hs = '{0, 10, 31, 32, 40, 63, 64, 100};
            nb = $urandom_range(0, 6);
            for (int i = 0; i < nb; i++) begin
                bt[i] = $urandom_range(0, 7);
                bl[i] = $urandom_range(0, 2);
                bd[i] = $urandom_range(0, 250);
            end
            run_frame($urandom_range(0, 2), hs[$urandom_range(0, 7)],
                      $urandom_range(0, 1), 1'($urandom_range(0, 1)),
                      $sformatf("rand%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
